// File: rtl/bcd_display_ctrl_pkg.sv
// Shared types and constants for the BCD display controller.
// Imported by the interface, the top and the digit scanner.
package bcd_ctrl_pkg;

    localparam int DIGITS = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 5;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    // Double-dabble correction: add 3 to every nibble >= 5.
    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3
                                                : b[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_display_ctrl_if.sv
// Conversion request/result bundle for bcd_display_ctrl.
// master issues load/data; slave returns busy/done and the digits.
interface bcd_display_ctrl_if;
    import bcd_ctrl_pkg::*;

    logic              load;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic [3:0]        data3;
    logic [3:0]        data2;
    logic [3:0]        data1;
    logic [3:0]        data0;

    modport master (
        output load,
        output data,
        input  busy,
        input  done,
        input  data3,
        input  data2,
        input  data1,
        input  data0
    );

    modport slave (
        input  load,
        input  data,
        output busy,
        output done,
        output data3,
        output data2,
        output data1,
        output data0
    );

endinterface

// File: rtl/bcd_display_ctrl_digit_scan.sv
// Seven-segment digit multiplexer: prescaler, slot index, blanking.
// Leading-zero blanking is compiled in with BCD_BLANK_LEAD_ZERO_EN.
module digit_scan
    import bcd_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic [3:0] data3,
    input  logic [3:0] data2,
    input  logic [3:0] data1,
    input  logic [3:0] data0,
    output logic [3:0] digit_sel,
    output logic [3:0] digit_bcd
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);

    logic [PW-1:0] pre;
    logic [1:0]    idx;
    logic [1:0]    idx_n;
    logic          tc;
    logic [3:0]    dig [DIGITS];
    logic [3:0]    blank;
    logic [3:0]    sel_n;
    logic [3:0]    bcd_n;

    assign dig[0] = data0;
    assign dig[1] = data1;
    assign dig[2] = data2;
    assign dig[3] = data3;

    assign tc    = (pre == TC);
    assign idx_n = tc ? idx + 2'd1 : idx;

    always_comb begin
        blank = 4'b0000;
`ifdef BCD_BLANK_LEAD_ZERO_EN
        // Units digit is never blanked so a zero result still shows "0".
        blank[3] = (data3 == 4'd0);
        blank[2] = blank[3] && (data2 == 4'd0);
        blank[1] = blank[2] && (data1 == 4'd0);
`endif
    end

    always_comb begin
        sel_n = ~(4'b0001 << idx_n);
        bcd_n = dig[idx_n];
        if (blank[idx_n]) begin
            sel_n = 4'b1111;
            bcd_n = BLANK_CODE;
        end
    end

    // Outputs follow the next index so they move on the same edge as it.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            pre       <= '0;
            idx       <= 2'd0;
            digit_sel <= 4'b1110;
            digit_bcd <= 4'd0;
        end else begin
            pre       <= tc ? '0 : pre + 1'b1;
            idx       <= idx_n;
            digit_sel <= sel_n;
            digit_bcd <= bcd_n;
        end
    end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD (mod 10000) iterative converter with display scan.
// Optional BCD_BLANK_LEAD_ZERO_EN enables leading-zero blanking.
module bcd_display_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic               in_clk,
    input  logic               rst,
    bcd_display_ctrl_if.slave  bus,
    output logic [3:0]         digit_sel,
    output logic [3:0]         digit_bcd
);

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] bin;
    logic [15:0]       bcd;
    logic [15:0]       corr;
    logic [CNT_W-1:0]  cnt;
    logic              start;
    logic              step;
    logic              commit;
    logic              done_q;
    logic [3:0]        d3, d2, d1, d0;

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.load) state_n = SHIFT;
            SHIFT:   if (cnt == CNT_W'(DATA_W - 1)) state_n = COMMIT;
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        start  = (state == IDLE) && bus.load;
        step   = (state == SHIFT);
        commit = (state == COMMIT);
    end

    assign corr = add3(bcd);

    // Carry out of the thousands nibble is dropped: result is mod 10000.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            bin    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            d3     <= 4'd0;
            d2     <= 4'd0;
            d1     <= 4'd0;
            d0     <= 4'd0;
        end else begin
            done_q <= commit;
            if (start) begin
                bin <= bus.data;
                bcd <= '0;
                cnt <= '0;
            end else if (step) begin
                bcd <= {corr[14:0], bin[DATA_W-1]};
                bin <= {bin[DATA_W-2:0], 1'b0};
                cnt <= cnt + 1'b1;
            end
            if (commit) begin
                d3 <= bcd[15:12];
                d2 <= bcd[11:8];
                d1 <= bcd[7:4];
                d0 <= bcd[3:0];
            end
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
    assign bus.data3 = d3;
    assign bus.data2 = d2;
    assign bus.data1 = d1;
    assign bus.data0 = d0;

    digit_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .in_clk    (in_clk),
        .rst       (rst),
        .data3     (d3),
        .data2     (d2),
        .data1     (d1),
        .data0     (d0),
        .digit_sel (digit_sel),
        .digit_bcd (digit_bcd)
    );

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: conversion table, busy-load,
// mid-conversion reset and digit scan with SCAN_DIV=4.
module tb_bcd_display_ctrl;

    logic       in_clk = 1'b0;
    logic       rst;
    logic [3:0] digit_sel;
    logic [3:0] digit_bcd;
    int         errors = 0;
    int         checks = 0;
    int         ecnt   = 0;
    logic [15:0] last_exp;

    bcd_display_ctrl_if bus ();

    bcd_display_ctrl #(
        .SCAN_DIV (4)
    ) dut (
        .in_clk    (in_clk),
        .rst       (rst),
        .bus       (bus),
        .digit_sel (digit_sel),
        .digit_bcd (digit_bcd)
    );

    always #5 in_clk = ~in_clk;

    always @(posedge in_clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    typedef struct {
        logic [31:0] v;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] digs();
        return {bus.data3, bus.data2, bus.data1, bus.data0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " busy"}, 32'(bus.busy), 0);
        chk({nm, " done"}, 32'(bus.done), 0);
        chk({nm, " digits"}, 32'(digs()), 0);
        chk({nm, " sel"}, 32'(digit_sel), 32'hE);
        chk({nm, " bcd"}, 32'(digit_bcd), 0);
    endtask

    task automatic run_conv(input logic [31:0] v, input logic [15:0] exp,
                            input string nm);
        int bc = 0;
        int dc = 0;
        logic [15:0] at_done = 'x;
        logic [15:0] mid = 'x;
        @(negedge in_clk);
        bus.load = 1'b1;
        bus.data = v;
        @(posedge in_clk);
        #1 bus.load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge in_clk);
            if (bus.busy) bc++;
            if (bus.done) begin
                dc++;
                at_done = digs();
            end
            if (i == 20) mid = digs();
        end
        chk({nm, " busy cycles"}, bc, 33);
        chk({nm, " done pulses"}, dc, 1);
        chk({nm, " held digits"}, 32'(mid), 32'(last_exp));
        chk({nm, " result"}, 32'(at_done), 32'(exp));
        last_exp = exp;
    endtask

    task automatic check_scan(input logic [15:0] d, input string nm);
        int k = 0;
        logic [3:0] es, eb, dg;
        logic       bl;
        while ((ecnt % 16) != 0 && k < 64) begin
            @(negedge in_clk);
            k++;
        end
        chk({nm, " align timeout"}, 32'(k < 64), 1);
        for (int j = 0; j < 16; j++) begin
            int s = j / 4;
            dg = d[s*4 +: 4];
            bl = 1'b0;
`ifdef BCD_BLANK_LEAD_ZERO_EN
            if (s > 0 && (d >> (s*4)) == 16'd0) bl = 1'b1;
`endif
            es = bl ? 4'b1111 : ~(4'b0001 << s);
            eb = bl ? 4'hF : dg;
            chk($sformatf("%s sel j%0d", nm, j), 32'(digit_sel), 32'(es));
            chk($sformatf("%s bcd j%0d", nm, j), 32'(digit_bcd), 32'(eb));
            @(negedge in_clk);
        end
    endtask

    initial begin
        int dc;
        vecs[0] = '{32'd1234,       16'h1234, "v1234"};
        vecs[1] = '{32'hFFFFFFFF,   16'h7295, "vmax"};
        vecs[2] = '{32'd10000,      16'h0000, "v10000"};
        vecs[3] = '{32'd9999,       16'h9999, "v9999"};
        vecs[4] = '{32'd100000007,  16'h0007, "v1e8p7"};
        vecs[5] = '{32'd56,         16'h0056, "v56"};
        vecs[6] = '{32'd0,          16'h0000, "v0"};
        vecs[7] = '{32'd8765,       16'h8765, "v8765"};

        rst      = 1'b0;
        bus.load = 1'b0;
        bus.data = '0;
        last_exp = 16'h0;
        #12;
        chk_reset("por");
        @(negedge in_clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++)
            run_conv(vecs[i].v, vecs[i].exp, vecs[i].nm);

        // Second load at E5 must be ignored.
        @(negedge in_clk);
        bus.load = 1'b1;
        bus.data = 32'd56;
        @(posedge in_clk);
        #1 bus.load = 1'b0;
        repeat (4) @(posedge in_clk);
        @(negedge in_clk);
        bus.load = 1'b1;
        bus.data = 32'd9999;
        @(posedge in_clk);
        #1 bus.load = 1'b0;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge in_clk);
            if (bus.done) dc++;
        end
        chk("busyload done pulses", dc, 1);
        chk("busyload result", 32'(digs()), 32'h0056);
        chk("busyload idle", 32'(bus.busy), 0);
        last_exp = 16'h0056;
        run_conv(32'd9999, 16'h9999, "after busy");

        // Reset partway through a conversion.
        @(negedge in_clk);
        bus.load = 1'b1;
        bus.data = 32'd8765;
        @(posedge in_clk);
        #1 bus.load = 1'b0;
        repeat (9) @(posedge in_clk);
        @(negedge in_clk);
        rst = 1'b0;
        #1;
        chk_reset("midreset");
        repeat (2) @(negedge in_clk);
        rst = 1'b1;
        dc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge in_clk);
            if (bus.done) dc++;
        end
        chk("midreset no done", dc, 0);
        last_exp = 16'h0;
        run_conv(32'd8765, 16'h8765, "fresh 8765");

        // Scan timing from reset release.
        @(negedge in_clk);
        rst = 1'b0;
        @(negedge in_clk);
        rst = 1'b1;
        last_exp = 16'h0;
        repeat (3) @(negedge in_clk);
        chk("scan slot0 hold", 32'(digit_sel), 32'hE);
        @(negedge in_clk);
        chk("scan first step", 32'(digit_sel), 32'hD);

        run_conv(32'd42, 16'h0042, "v42");
        check_scan(16'h0042, "scan42");
        run_conv(32'd0, 16'h0000, "v0b");
        check_scan(16'h0000, "scan0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
